// File: rtl/sseg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sseg_pkg : shared segment types, glyph table and hex decode helper
// Rev 1.0
// ---------------------------------------------------------------------------
package sseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Active-low glyphs, bit order g..a; entry n sits at index n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,  // F E d C
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,  // b A 9 8
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,  // 7 6 5 4
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000   // 3 2 1 0
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_mux_driver_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sseg_mux_driver_if : load/mask inputs and scanned display pins
// Rev 1.0
// ---------------------------------------------------------------------------
interface sseg_mux_driver_if #(
  parameter int NUM_DIGITS = 4
);
  import sseg_pkg::*;

  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_en;
  logic                    ld;
  logic                    pending;
  logic                    frame_done;
  seg_t                    seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;

  modport master (
    output data_in, dp_in, digit_en, lz_en, ld,
    input  pending, frame_done, seg, dp, an
  );

  modport slave (
    input  data_in, dp_in, digit_en, lz_en, ld,
    output pending, frame_done, seg, dp, an
  );

endinterface
`default_nettype wire

// File: rtl/hex_sseg_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hex_sseg_decode : combinational nibble to active-low segment pattern
// Rev 1.0
// ---------------------------------------------------------------------------
module hex_sseg_decode
  import sseg_pkg::*;
(
  input  wire logic [3:0] nibble,
  output seg_t            seg
);

  assign seg = hex_to_seg(nibble);

endmodule
`default_nettype wire

// File: rtl/sseg_mux_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sseg_mux_driver : time-multiplexed hex display driver with frame-aligned
// staged loads, digit mask, decimal points and leading-zero blanking
// Rev 1.0
// ---------------------------------------------------------------------------
module sseg_mux_driver
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  wire logic         clk,
  input  wire logic         rst,
  sseg_mux_driver_if.slave  bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_stage;
  logic [NUM_DIGITS-1:0]   r_stage_dp;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic                    r_pending;
  logic                    r_frame_done;
  logic [NUM_DIGITS-1:0]   r_an;
  seg_t                    r_seg;
  logic                    r_dp;

  logic                    w_tc;
  logic                    w_wrap;
  logic [3:0]              w_nibble;
  seg_t                    w_dec_seg;
  logic [NUM_DIGITS-1:0]   w_upper_zero;
  logic                    w_run;
  logic                    w_blank;
  logic                    w_vis;
  logic [NUM_DIGITS-1:0]   w_onehot;

  assign w_tc     = (r_cnt == c_cnt_last);
  assign w_wrap   = w_tc && (r_idx == c_idx_last);
  assign w_nibble = r_shadow[{r_idx, 2'b00} +: 4];
  assign w_onehot = NUM_DIGITS'(1) << r_idx;

  hex_sseg_decode u_decode (
    .nibble (w_nibble),
    .seg    (w_dec_seg)
  );

  // w_upper_zero[i] is set when nibbles NUM_DIGITS-1 down to i are all zero.
  always_comb begin
    w_run        = 1'b1;
    w_upper_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_run           = w_run & (r_shadow[4*i +: 4] == 4'h0);
      w_upper_zero[i] = w_run;
    end
  end

  assign w_blank = bus.lz_en && (r_idx != '0) && w_upper_zero[r_idx];
  assign w_vis   = bus.digit_en[r_idx] && !w_blank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_stage      <= '0;
      r_stage_dp   <= '0;
      r_shadow     <= '0;
      r_shadow_dp  <= '0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
      r_an         <= '1;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
    end else begin
      r_frame_done <= w_wrap;

      if (w_tc) begin
        r_cnt <= '0;
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      // A load landing on the wrap goes straight to the shadow so it is not
      // held back for a whole extra frame.
      if (bus.ld) begin
        if (w_wrap) begin
          r_shadow    <= bus.data_in;
          r_shadow_dp <= bus.dp_in;
          r_pending   <= 1'b0;
        end else begin
          r_stage    <= bus.data_in;
          r_stage_dp <= bus.dp_in;
          r_pending  <= 1'b1;
        end
      end else if (w_wrap && r_pending) begin
        r_shadow    <= r_stage;
        r_shadow_dp <= r_stage_dp;
        r_pending   <= 1'b0;
      end

      r_an  <= w_vis ? ~w_onehot : '1;
      r_seg <= w_vis ? w_dec_seg : SEG_BLANK;
      r_dp  <= w_vis ? ~r_shadow_dp[r_idx] : 1'b1;
    end
  end

  assign bus.pending    = r_pending;
  assign bus.frame_done = r_frame_done;
  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_sseg_mux_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sseg_mux_driver : directed self-checking bench, NUM_DIGITS=4, REFRESH_DIV=4
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sseg_mux_driver;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sseg_mux_driver_if #(.NUM_DIGITS(4)) bus ();

  sseg_mux_driver #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Returns at the negedge where frame_done is seen high.
  task automatic wait_fd();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_done && n < 40);
    checks++;
    if (bus.frame_done !== 1'b1) begin
      errors++;
      $display("FAIL frame_wait frame_done=%b required 1", bus.frame_done);
    end
  endtask

  task automatic pulse_ld(input logic [15:0] d, input logic [3:0] p);
    bus.data_in = d;
    bus.dp_in   = p;
    bus.ld      = 1'b1;
    @(negedge clk);
    bus.ld      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.an !== 4'b1111) begin errors++; $display("FAIL reset_an got %b required 1111", bus.an); end
    checks++;
    if (bus.seg !== 7'b1111111) begin errors++; $display("FAIL reset_seg got %b required 1111111", bus.seg); end
    checks++;
    if (bus.dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b required 1", bus.dp); end
    checks++;
    if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b required 0", bus.frame_done); end
    checks++;
    if (bus.pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b required 0", bus.pending); end
  endtask

  task automatic test_scan();
    logic [3:0] exp_an;
    logic       exp_fd;
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << (((i - 1) / 4) % 4));
      exp_fd = (i % 16 == 0);
      checks++;
      if (bus.an !== exp_an) begin errors++; $display("FAIL scan_an[%0d] got %b required %b", i, bus.an, exp_an); end
      checks++;
      if (bus.seg !== 7'b1000000) begin errors++; $display("FAIL scan_seg[%0d] got %b required 1000000", i, bus.seg); end
      checks++;
      if (bus.frame_done !== exp_fd) begin errors++; $display("FAIL scan_fd[%0d] got %b required %b", i, bus.frame_done, exp_fd); end
    end
  endtask

  task automatic test_staged_load();
    logic [6:0] exp_seg [4];
    logic       exp_dp  [4];
    logic [3:0] exp_an;
    exp_seg = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
    exp_dp  = '{1'b1, 1'b0, 1'b1, 1'b1};
    wait_fd();
    repeat (4) @(negedge clk);
    pulse_ld(16'h12AF, 4'b0010);
    checks++;
    if (bus.pending !== 1'b1) begin errors++; $display("FAIL load_pending got %b required 1", bus.pending); end
    for (int n = 0; n < 40 && !bus.frame_done; n++) begin
      @(negedge clk);
      checks++;
      if (bus.seg !== 7'b1000000) begin errors++; $display("FAIL load_hold_seg got %b required 1000000", bus.seg); end
    end
    checks++;
    if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL load_wrap frame_done=%b required 1", bus.frame_done); end
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        exp_an = ~(4'b0001 << d);
        checks++;
        if (bus.an !== exp_an) begin errors++; $display("FAIL load_an[%0d] got %b required %b", d, bus.an, exp_an); end
        checks++;
        if (bus.seg !== exp_seg[d]) begin errors++; $display("FAIL load_seg[%0d] got %b required %b", d, bus.seg, exp_seg[d]); end
        checks++;
        if (bus.dp !== exp_dp[d]) begin errors++; $display("FAIL load_dp[%0d] got %b required %b", d, bus.dp, exp_dp[d]); end
      end
    end
    checks++;
    if (bus.pending !== 1'b0) begin errors++; $display("FAIL load_pending_clr got %b required 0", bus.pending); end
  endtask

  task automatic test_wrap_load();
    logic [3:0] exp_an;
    wait_fd();
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      checks++;
      if (bus.pending !== 1'b0) begin errors++; $display("FAIL wrap_pre_pending got %b required 0", bus.pending); end
    end
    pulse_ld(16'h3333, 4'b0000);
    checks++;
    if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL wrap_fd got %b required 1", bus.frame_done); end
    checks++;
    if (bus.pending !== 1'b0) begin errors++; $display("FAIL wrap_pending got %b required 0", bus.pending); end
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        exp_an = ~(4'b0001 << d);
        checks++;
        if (bus.an !== exp_an) begin errors++; $display("FAIL wrap_an[%0d] got %b required %b", d, bus.an, exp_an); end
        checks++;
        if (bus.seg !== 7'b0110000) begin errors++; $display("FAIL wrap_seg[%0d] got %b required 0110000", d, bus.seg); end
        checks++;
        if (bus.pending !== 1'b0) begin errors++; $display("FAIL wrap_post_pending got %b required 0", bus.pending); end
      end
    end
  endtask

  task automatic test_lz();
    logic [3:0] exp_an  [4];
    logic [6:0] exp_seg [4];
    bus.lz_en = 1'b1;
    pulse_ld(16'h0050, 4'b0000);
    wait_fd();
    exp_an  = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    exp_seg = '{7'b1000000, 7'b0010010, 7'b1111111, 7'b1111111};
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        checks++;
        if (bus.an !== exp_an[d]) begin errors++; $display("FAIL lz50_an[%0d] got %b required %b", d, bus.an, exp_an[d]); end
        checks++;
        if (bus.seg !== exp_seg[d]) begin errors++; $display("FAIL lz50_seg[%0d] got %b required %b", d, bus.seg, exp_seg[d]); end
      end
    end
    pulse_ld(16'h0000, 4'b0000);
    wait_fd();
    exp_an  = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    exp_seg = '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111};
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        checks++;
        if (bus.an !== exp_an[d]) begin errors++; $display("FAIL lz00_an[%0d] got %b required %b", d, bus.an, exp_an[d]); end
        checks++;
        if (bus.seg !== exp_seg[d]) begin errors++; $display("FAIL lz00_seg[%0d] got %b required %b", d, bus.seg, exp_seg[d]); end
      end
    end
    bus.lz_en = 1'b0;
  endtask

  task automatic test_enable_mask();
    logic [3:0] exp_an  [4];
    logic [6:0] exp_seg [4];
    bus.digit_en = 4'b0101;
    pulse_ld(16'h8888, 4'b0000);
    wait_fd();
    exp_an  = '{4'b1110, 4'b1111, 4'b1011, 4'b1111};
    exp_seg = '{7'b0000000, 7'b1111111, 7'b0000000, 7'b1111111};
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        checks++;
        if (bus.an !== exp_an[d]) begin errors++; $display("FAIL en_an[%0d] got %b required %b", d, bus.an, exp_an[d]); end
        checks++;
        if (bus.seg !== exp_seg[d]) begin errors++; $display("FAIL en_seg[%0d] got %b required %b", d, bus.seg, exp_seg[d]); end
      end
    end
    bus.digit_en = 4'b1111;
  endtask

  task automatic test_mid_reset();
    wait_fd();
    repeat (4) @(negedge clk);
    pulse_ld(16'h1234, 4'b1111);
    checks++;
    if (bus.pending !== 1'b1) begin errors++; $display("FAIL mr_pending got %b required 1", bus.pending); end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.an !== 4'b1011) begin errors++; $display("FAIL mr_idx2_an got %b required 1011", bus.an); end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.an !== 4'b1111) begin errors++; $display("FAIL mr_an got %b required 1111", bus.an); end
    checks++;
    if (bus.seg !== 7'b1111111) begin errors++; $display("FAIL mr_seg got %b required 1111111", bus.seg); end
    checks++;
    if (bus.dp !== 1'b1) begin errors++; $display("FAIL mr_dp got %b required 1", bus.dp); end
    checks++;
    if (bus.pending !== 1'b0) begin errors++; $display("FAIL mr_pending_clr got %b required 0", bus.pending); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus.an !== ((i <= 4) ? 4'b1110 : 4'b1101)) begin errors++; $display("FAIL mr_restart_an[%0d] got %b", i, bus.an); end
      checks++;
      if (bus.seg !== 7'b1000000) begin errors++; $display("FAIL mr_restart_seg[%0d] got %b required 1000000", i, bus.seg); end
      checks++;
      if (bus.pending !== 1'b0) begin errors++; $display("FAIL mr_restart_pending[%0d] got %b required 0", i, bus.pending); end
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.data_in  = 16'h0000;
    bus.dp_in    = 4'b0000;
    bus.digit_en = 4'b1111;
    bus.lz_en    = 1'b0;
    bus.ld       = 1'b0;
    test_reset();
    test_scan();
    test_staged_load();
    test_wrap_load();
    test_lz();
    test_enable_mask();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
